// File: rtl/ring_osc_meter_pkg.sv
// Ring-oscillator delay meter: shared types and constants.
// FSM states, settle/synchroniser depths, select-width helper.
`timescale 1ns/1ps
package ring_osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    DONE
  } state_t;

  localparam int SETTLE_CYC  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int SET_W       = $clog2(SETTLE_CYC);

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_osc_meter_if.sv
// Ring-oscillator delay meter: host and ring-loop signal bundle.
// ring_o/ring_fb carry each ring's loop through the tile switches.
`timescale 1ns/1ps
interface ring_osc_meter_if #(
  parameter int N_RINGS = 4,
  parameter int GATE_W  = 16,
  parameter int CNT_W   = 16
);
  import ring_osc_meter_pkg::*;

  localparam int SEL_W = sel_width(N_RINGS);

  logic               start;
  logic [SEL_W-1:0]   ring_sel;
  logic [GATE_W-1:0]  gate_len;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               ring_tap;
  logic [N_RINGS-1:0] ring_o;
  logic [N_RINGS-1:0] ring_fb;

  modport master (
    output start, ring_sel, gate_len, ring_fb,
    input  busy, done, count, overflow, ring_tap, ring_o
  );

  modport slave (
    input  start, ring_sel, gate_len, ring_fb,
    output busy, done, count, overflow, ring_tap, ring_o
  );

endinterface

// File: rtl/ring_osc_meter_stage_chain.sv
// Gated inverter chain (NAND + inverters) with ripple prescaler.
// Loop closes outside through fb_i; prescaler cleared while en_i low.
`timescale 1ns/1ps
module ring_osc_stage_chain #(
  parameter int N_STAGES = 5,
  parameter int DIV_W    = 4
) (
  input  logic en_i,
  input  logic fb_i,
  output logic osc_o,
  output logic tap_o
);

  (* dont_touch = "true", keep = "true" *)
  logic [N_STAGES-1:0] node;
  logic [DIV_W-1:0]    div;

  nand g_nand (node[0], en_i, fb_i);

  for (genvar s = 1; s < N_STAGES; s++) begin : g_inv
    not g_not (node[s], node[s-1]);
  end

  assign osc_o = node[N_STAGES-1];

  for (genvar b = 0; b < DIV_W; b++) begin : g_div
    logic ck;
    logic t_q;
    if (b == 0) begin : g_first
      assign ck = osc_o;
    end else begin : g_next
      assign ck = ~div[b-1];
    end
    // toggle stage; enable low is the only async clear in the block
    always_ff @(posedge ck or negedge en_i) begin
      if (!en_i) t_q <= 1'b0;
      else       t_q <= ~t_q;
    end
    assign div[b] = t_q;
  end

  assign tap_o = div[DIV_W-1];

endmodule

// File: rtl/ring_osc_meter.sv
// Ring-oscillator delay meter top: FSM, gate window, sync, counter.
// One ring enabled per measurement; prescaled edges counted in clk.
`timescale 1ns/1ps
module ring_osc_meter #(
  parameter int N_RINGS  = 4,
  parameter int N_STAGES = 5,
  parameter int DIV_W    = 4,
  parameter int GATE_W   = 16,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst,
  ring_osc_meter_if.slave bus
);
  import ring_osc_meter_pkg::*;

  localparam int SEL_W = sel_width(N_RINGS);

  state_t                state_q, state_d;
  logic [GATE_W-1:0]     gate_q, gate_d;
  logic [SET_W-1:0]      set_q, set_d;
  logic [N_RINGS-1:0]    en_q, en_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  edge_q;
  logic [N_RINGS-1:0]    ring_en;
  logic [N_RINGS-1:0]    tap_msb;
  logic                  tap;
  logic                  rise;

  // reset kills the ring combinationally, not one edge later
  assign ring_en = rst ? '0 : en_q;

  for (genvar r = 0; r < N_RINGS; r++) begin : g_ring
    ring_osc_stage_chain #(
      .N_STAGES (N_STAGES),
      .DIV_W    (DIV_W)
    ) u_chain (
      .en_i  (ring_en[r]),
      .fb_i  (bus.ring_fb[r]),
      .osc_o (bus.ring_o[r]),
      .tap_o (tap_msb[r])
    );
  end

  // at most one enable is set, so the OR acts as the select mux
  assign tap  = |(tap_msb & ring_en);
  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // synchroniser and rising-edge detector for the prescaled tap
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tap};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // measurement state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gate_q  <= '0;
      set_q   <= '0;
      en_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      set_q   <= set_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // next state: accept start, settle, count window, freeze result
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    set_d   = set_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SETTLE;
          set_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          gate_d  = (bus.gate_len == '0) ? GATE_W'(1)
                                         : bus.gate_len;
          for (int k = 0; k < N_RINGS; k++) begin
            en_d[k] = (bus.ring_sel == SEL_W'(k));
          end
        end
      end
      SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = GATE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      GATE: begin
        // overflow marks an edge lost at the saturated value
        if (rise) begin
          if (&cnt_q) ovf_d = 1'b1;
          else        cnt_d = cnt_q + CNT_W'(1);
        end
        if (gate_q == GATE_W'(1)) begin
          state_d = DONE;
          en_d    = '0;
        end else begin
          gate_d = gate_q - GATE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == SETTLE) || (state_q == GATE);
  assign bus.done     = (state_q == DONE);
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
  assign bus.ring_tap = tap;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: two instances (4 rings/16-bit,
// 3 rings/4-bit count), rings closed by a 1 ns half-period loop model.
`timescale 1ns/1ps
module tb_ring_osc_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   tog [4];
  int   tog_s [3];

  ring_osc_meter_if #(.N_RINGS(4), .GATE_W(16), .CNT_W(16)) bm ();
  ring_osc_meter_if #(.N_RINGS(3), .GATE_W(16), .CNT_W(4))  bs ();

  ring_osc_meter #(
    .N_RINGS(4), .N_STAGES(5), .DIV_W(4), .GATE_W(16), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  ring_osc_meter #(
    .N_RINGS(3), .N_STAGES(5), .DIV_W(4), .GATE_W(16), .CNT_W(4)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs)
  );

  always #5 clk = ~clk;

  // Ring loop: 5 stages x 200 ps lumped into a 1 ns feedback step,
  // giving a 2 ns ring and a 32 ns tap (below the clk/2 limit; a
  // 100 ps stage would give a 16 ns tap that the sampler aliases).
  // Steps sit at x.3 ns so tap edges never coincide with clk edges.
  initial begin
    bm.ring_fb = '1;
    bs.ring_fb = '1;
    for (int k = 0; k < 4; k++) tog[k] = 0;
    for (int k = 0; k < 3; k++) tog_s[k] = 0;
    #0.3;
    forever begin
      #1;
      for (int k = 0; k < 4; k++)
        if (bm.ring_fb[k] !== bm.ring_o[k]) tog[k]++;
      for (int k = 0; k < 3; k++)
        if (bs.ring_fb[k] !== bs.ring_o[k]) tog_s[k]++;
      bm.ring_fb = bm.ring_o;
      bs.ring_fb = bs.ring_o;
    end
  end

  task automatic go_m(input logic [1:0] sel, input logic [15:0] len);
    bm.ring_sel = sel;
    bm.gate_len = len;
    bm.start    = 1'b1;
    @(negedge clk);
    bm.start    = 1'b0;
  endtask

  task automatic go_s(input logic [1:0] sel, input logic [15:0] len);
    bs.ring_sel = sel;
    bs.gate_len = len;
    bs.start    = 1'b1;
    @(negedge clk);
    bs.start    = 1'b0;
  endtask

  task automatic wait_m(input int budget, output int n);
    n = 0;
    while (bm.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_s(input int budget, output int n);
    n = 0;
    while (bs.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bm.busy !== 1'b0 || bm.done !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0",
               bm.busy, bm.done);
    end
    checks++;
    if (bm.count !== 16'd0 || bm.overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset_count: count=%0d ovf=%b want 0 0",
               bm.count, bm.overflow);
    end
    checks++;
    if (bm.ring_o !== 4'hF || bs.ring_o !== 3'h7) begin
      errs++;
      $display("FAIL reset_rings: ring_o=%h/%h want f/7",
               bm.ring_o, bs.ring_o);
    end
    checks++;
    if (bm.ring_tap !== 1'b0) begin
      errs++;
      $display("FAIL reset_tap: got %b want 0", bm.ring_tap);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bm.busy !== 1'b0 || bs.busy !== 1'b0) begin
      errs++;
      $display("FAIL idle_busy: got %b/%b want 0/0", bm.busy, bs.busy);
    end
  endtask

  task automatic test_measure();
    int n;
    int t0 [4];
    for (int k = 0; k < 4; k++) t0[k] = tog[k];
    go_m(2'd0, 16'd1000);
    checks++;
    if (bm.busy !== 1'b1 || bm.done !== 1'b0) begin
      errs++;
      $display("FAIL meas_busy: busy=%b done=%b want 1 0",
               bm.busy, bm.done);
    end
    wait_m(2000, n);
    checks++;
    if (n != 1004) begin
      errs++;
      $display("FAIL meas_len: cycles=%0d want 1004", n);
    end
    checks++;
    if (bm.count < 16'd311 || bm.count > 16'd314) begin
      errs++;
      $display("FAIL meas_count: got %0d want 311..314", bm.count);
    end
    checks++;
    if (bm.overflow !== 1'b0 || bm.ring_tap !== 1'b0) begin
      errs++;
      $display("FAIL meas_ovf_tap: ovf=%b tap=%b want 0 0",
               bm.overflow, bm.ring_tap);
    end
    checks++;
    if (tog[0] - t0[0] < 1000 || tog[1] != t0[1] ||
        tog[2] != t0[2] || tog[3] != t0[3]) begin
      errs++;
      $display("FAIL meas_rings: toggles %0d %0d %0d %0d want >=1000 0 0 0",
               tog[0]-t0[0], tog[1]-t0[1], tog[2]-t0[2], tog[3]-t0[3]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bm.done !== 1'b1 || bm.count < 16'd311 || bm.count > 16'd314) begin
      errs++;
      $display("FAIL meas_hold: done=%b count=%0d want 1 311..314",
               bm.done, bm.count);
    end
  endtask

  task automatic test_gate_zero();
    int n;
    go_m(2'd1, 16'd0);
    wait_m(50, n);
    checks++;
    if (n != 5) begin
      errs++;
      $display("FAIL gate0_len: cycles=%0d want 5", n);
    end
    checks++;
    if (bm.count > 16'd1 || bm.overflow !== 1'b0) begin
      errs++;
      $display("FAIL gate0_count: count=%0d ovf=%b want <=1 0",
               bm.count, bm.overflow);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    int t0 [4];
    for (int k = 0; k < 4; k++) t0[k] = tog[k];
    go_m(2'd2, 16'd1000);
    repeat (100) @(negedge clk);
    go_m(2'd0, 16'd5);
    checks++;
    if (bm.busy !== 1'b1) begin
      errs++;
      $display("FAIL ign_busy: got %b want 1", bm.busy);
    end
    repeat (400) @(negedge clk);
    go_m(2'd1, 16'd0);
    wait_m(2000, n);
    checks++;
    if (n != 502) begin
      errs++;
      $display("FAIL ign_len: remaining cycles=%0d want 502", n);
    end
    checks++;
    if (bm.count < 16'd311 || bm.count > 16'd314) begin
      errs++;
      $display("FAIL ign_count: got %0d want 311..314", bm.count);
    end
    checks++;
    if (tog[2] - t0[2] < 1000 || tog[0] != t0[0] ||
        tog[1] != t0[1] || tog[3] != t0[3]) begin
      errs++;
      $display("FAIL ign_rings: toggles %0d %0d %0d %0d want 0 0 >=1000 0",
               tog[0]-t0[0], tog[1]-t0[1], tog[2]-t0[2], tog[3]-t0[3]);
    end
  endtask

  task automatic test_rst_mid();
    int t1;
    go_m(2'd1, 16'd1000);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bm.ring_o !== 4'hF || bm.ring_tap !== 1'b0) begin
      errs++;
      $display("FAIL rst_same_cycle: ring_o=%h tap=%b want f 0",
               bm.ring_o, bm.ring_tap);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bm.busy !== 1'b0 || bm.done !== 1'b0 || bm.count !== 16'd0) begin
      errs++;
      $display("FAIL rst_mid: busy=%b done=%b count=%0d want 0 0 0",
               bm.busy, bm.done, bm.count);
    end
    rst = 1'b0;
    t1 = tog[1];
    repeat (5) @(negedge clk);
    checks++;
    if (bm.busy !== 1'b0 || bm.done !== 1'b0 || tog[1] != t1) begin
      errs++;
      $display("FAIL rst_after: busy=%b done=%b ring1 toggles=%0d want 0 0 0",
               bm.busy, bm.done, tog[1] - t1);
    end
  endtask

  task automatic test_overflow();
    int n;
    go_s(2'd0, 16'd100);
    wait_s(300, n);
    checks++;
    if (n != 104) begin
      errs++;
      $display("FAIL ovf_len: cycles=%0d want 104", n);
    end
    checks++;
    if (bs.count !== 4'd15 || bs.overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_sat: count=%0d ovf=%b want 15 1",
               bs.count, bs.overflow);
    end
    go_s(2'd1, 16'd20);
    checks++;
    if (bs.count !== 4'd0 || bs.overflow !== 1'b0 || bs.done !== 1'b0) begin
      errs++;
      $display("FAIL ovf_clear: count=%0d ovf=%b done=%b want 0 0 0",
               bs.count, bs.overflow, bs.done);
    end
    wait_s(100, n);
    checks++;
    if (bs.count < 4'd5 || bs.count > 4'd7 || bs.overflow !== 1'b0) begin
      errs++;
      $display("FAIL short_count: count=%0d ovf=%b want 5..7 0",
               bs.count, bs.overflow);
    end
  endtask

  task automatic test_bad_sel();
    int n;
    int t0 [3];
    for (int k = 0; k < 3; k++) t0[k] = tog_s[k];
    go_s(2'd3, 16'd50);
    checks++;
    if (bs.busy !== 1'b1 || bs.ring_o !== 3'h7) begin
      errs++;
      $display("FAIL badsel_busy: busy=%b ring_o=%h want 1 7",
               bs.busy, bs.ring_o);
    end
    wait_s(100, n);
    checks++;
    if (n != 54 || bs.count !== 4'd0) begin
      errs++;
      $display("FAIL badsel_result: cycles=%0d count=%0d want 54 0",
               n, bs.count);
    end
    checks++;
    if (tog_s[0] != t0[0] || tog_s[1] != t0[1] || tog_s[2] != t0[2]) begin
      errs++;
      $display("FAIL badsel_rings: toggles %0d %0d %0d want 0 0 0",
               tog_s[0]-t0[0], tog_s[1]-t0[1], tog_s[2]-t0[2]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int t0 [4];
    for (int k = 0; k < 4; k++) t0[k] = tog[k];
    go_m(2'd1, 16'd50);
    wait_m(100, n);
    checks++;
    if (n != 54 || bm.count < 16'd14 || bm.count > 16'd17) begin
      errs++;
      $display("FAIL b2b_first: cycles=%0d count=%0d want 54 14..17",
               n, bm.count);
    end
    checks++;
    if (tog[1] - t0[1] < 40 || tog[0] != t0[0] ||
        tog[2] != t0[2] || tog[3] != t0[3]) begin
      errs++;
      $display("FAIL b2b_rings1: toggles %0d %0d %0d %0d want 0 >=40 0 0",
               tog[0]-t0[0], tog[1]-t0[1], tog[2]-t0[2], tog[3]-t0[3]);
    end
    for (int k = 0; k < 4; k++) t0[k] = tog[k];
    go_m(2'd3, 16'd50);
    checks++;
    if (bm.done !== 1'b0 || bm.busy !== 1'b1) begin
      errs++;
      $display("FAIL b2b_restart: done=%b busy=%b want 0 1",
               bm.done, bm.busy);
    end
    wait_m(100, n);
    checks++;
    if (n != 54 || bm.count < 16'd14 || bm.count > 16'd17) begin
      errs++;
      $display("FAIL b2b_second: cycles=%0d count=%0d want 54 14..17",
               n, bm.count);
    end
    checks++;
    if (tog[3] - t0[3] < 40 || tog[0] != t0[0] ||
        tog[1] != t0[1] || tog[2] != t0[2]) begin
      errs++;
      $display("FAIL b2b_rings3: toggles %0d %0d %0d %0d want 0 0 0 >=40",
               tog[0]-t0[0], tog[1]-t0[1], tog[2]-t0[2], tog[3]-t0[3]);
    end
  endtask

  initial begin
    bm.start    = 1'b0;
    bm.ring_sel = '0;
    bm.gate_len = '0;
    bs.start    = 1'b0;
    bs.ring_sel = '0;
    bs.gate_len = '0;
    @(negedge clk);
    test_reset();
    test_measure();
    test_gate_zero();
    test_start_ignored();
    test_rst_mid();
    test_overflow();
    test_bad_sel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
